// File: rtl/handshake_loop_ctrl_pkg.sv
// Shared definitions for the loop-trip controller.
// Contents: state register width, state encodings and the state type.
package handshake_loop_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/handshake_loop_ctrl_if.sv
// Handshake bundle of the loop-trip controller.
// Channels:
//   count/count_valid/count_ready           trip-count token into the controller
//   outs/outs_last/outs_valid/outs_ready    iteration-index tokens out
//   done_valid/done_ready                   dataless completion token out
// Modports: master = environment side, slave = controller side.
interface handshake_loop_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] count;
  logic                  count_valid;
  logic                  count_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_last;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  done_valid;
  logic                  done_ready;

  modport master (
    output count, count_valid, outs_ready, done_ready,
    input  count_ready, outs, outs_last, outs_valid, done_valid
  );

  modport slave (
    input  count, count_valid, outs_ready, done_ready,
    output count_ready, outs, outs_last, outs_valid, done_valid
  );

endinterface

// File: rtl/handshake_loop_ctrl_counter.sv
// Iteration counter: holds the current index and the trip limit.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         start a trip: idx <= 0, limit <= load_value
//   load_value   trip count N (must be nonzero when load is used)
//   inc          advance idx by one
//   value        current index
//   at_last      value == limit-1
module handshake_loop_counter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  inc,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  at_last
);

  logic [DATA_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      limit <= '0;
    end else if (load) begin
      idx   <= '0;
      limit <= load_value;
    end else if (inc) begin
      idx <= idx + DATA_WIDTH'(1);
    end
  end

  // Only meaningful while a trip runs (limit >= 1); with limit=0 after
  // reset the compare is against all-ones, which idx never reaches.
  assign at_last = (idx == (limit - DATA_WIDTH'(1)));
  assign value   = idx;

endmodule

// File: rtl/handshake_loop_ctrl.sv
// Elastic loop-trip controller: accepts one trip count N, emits indices
// 0..N-1 as handshake tokens, then one dataless completion token.
// Ports:
//   clk   clock (rising edge)
//   rst   asynchronous active-high reset
//   bus   handshake_loop_ctrl_if slave: count in, outs/done out
// All outputs decode registered state only; no ready/count feedthrough.
module handshake_loop_ctrl
  import handshake_loop_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  handshake_loop_ctrl_if.slave  bus
);

  state_t                state;
  state_t                state_next;
  logic                  load;
  logic                  inc;
  logic                  at_last;
  logic [DATA_WIDTH-1:0] value;

  handshake_loop_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(bus.count),
    .inc       (inc),
    .value     (value),
    .at_last   (at_last)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    inc        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.count_valid) begin
          // N=0 skips straight to completion without touching the counter
          if (bus.count == '0) begin
            state_next = ST_DONE;
          end else begin
            load       = 1'b1;
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.outs_ready) begin
          if (at_last) begin
            state_next = ST_DONE;
          end else begin
            inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.done_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign bus.count_ready = (state == ST_IDLE);
  assign bus.outs_valid  = (state == ST_RUN);
  assign bus.done_valid  = (state == ST_DONE);
  assign bus.outs        = value;
  assign bus.outs_last   = (state == ST_RUN) && at_last;

endmodule
